// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes, mux selects.
// The TRAP state exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP   = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ASA_PC    = 2'b00;
    localparam logic [1:0] ASA_OLDPC = 2'b01;
    localparam logic [1:0] ASA_RD1   = 2'b10;

    localparam logic [1:0] ASB_RD2   = 2'b00;
    localparam logic [1:0] ASB_IMM   = 2'b01;
    localparam logic [1:0] ASB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
        logic illegal;
    } opclass_t;

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier: maps instr[6:0] to a one-hot instruction class.
module op_class
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output opclass_t   cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_LOAD:   cls.load    = 1'b1;
            OP_STORE:  cls.store   = 1'b1;
            OP_RTYPE:  cls.rtype   = 1'b1;
            OP_ITYPE:  cls.itype   = 1'b1;
            OP_BRANCH: cls.branch  = 1'b1;
            OP_JAL:    cls.jal     = 1'b1;
            default:   cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core with memory-wait timeout supervision.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP and raise `illegal`.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] aluop,
    output logic       mem_req,
    output logic       retire,
    output logic       mem_timeout
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_t   state, state_nxt;
    opclass_t cls;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       wait_hit;
    logic pcupdate, branch;
    logic irwrite_s, memwrite_s, regwrite_s, retire_s, mem_req_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    op_class u_op_class (
        .op  (op),
        .cls (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (wait_hit)
                mem_timeout <= 1'b1;
        end
    end

    // A state change restarts the wait count; the FSM itself never abandons a wait.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        wait_hit     = 1'b0;
        if (state_nxt != state) begin
            wait_cnt_nxt = '0;
        end else if (mem_req_s && !mem_ready) begin
            wait_cnt_nxt = sat_inc(wait_cnt);
            wait_hit     = (32'(wait_cnt_nxt) >= WAIT_MAX);
        end
    end

    always_comb begin
        state_nxt  = state;
        adrsrc     = 1'b0;
        alusrca    = ASA_PC;
        alusrcb    = ASB_RD2;
        resultsrc  = RES_ALUOUT;
        aluop      = ALUOP_ADD;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        retire_s   = 1'b0;
        mem_req_s  = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb   = ASB_FOUR;
                resultsrc = RES_ALURESULT;
                mem_req_s = 1'b1;
                irwrite_s = mem_ready;
                pcupdate  = mem_ready;
                if (mem_ready)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrca = ASA_OLDPC;
                alusrcb = ASB_IMM;
                case (1'b1)
                    cls.load, cls.store: state_nxt = S_MEMADR;
                    cls.rtype:           state_nxt = S_EXECR;
                    cls.itype:           state_nxt = S_EXECI;
                    cls.branch:          state_nxt = S_BEQ;
                    cls.jal:             state_nxt = S_JAL;
                    cls.illegal: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_nxt = S_TRAP;
`else
                        state_nxt = S_FETCH;
                        retire_s  = 1'b1;
`endif
                    end
                    default:             state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca   = ASA_RD1;
                alusrcb   = ASB_IMM;
                state_nxt = cls.store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc    = 1'b1;
                mem_req_s = 1'b1;
                if (mem_ready)
                    state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                mem_req_s  = 1'b1;
                memwrite_s = mem_ready;
                retire_s   = mem_ready;
                if (mem_ready)
                    state_nxt = S_FETCH;
            end
            S_EXECR: begin
                alusrca   = ASA_RD1;
                alusrcb   = ASB_RD2;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alusrca   = ASA_RD1;
                alusrcb   = ASB_IMM;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                resultsrc  = RES_ALUOUT;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                alusrca   = ASA_RD1;
                alusrcb   = ASB_RD2;
                aluop     = ALUOP_SUB;
                resultsrc = RES_ALUOUT;
                branch    = 1'b1;
                retire_s  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                alusrca   = ASA_OLDPC;
                alusrcb   = ASB_FOUR;
                resultsrc = RES_ALUOUT;
                pcupdate  = 1'b1;
                state_nxt = S_ALUWB;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Enables are forced low while reset is held, even though FETCH would follow mem_ready.
    assign pcwrite  = reset_n & (pcupdate | (branch & zero));
    assign irwrite  = reset_n & irwrite_s;
    assign memwrite = reset_n & memwrite_s;
    assign regwrite = reset_n & regwrite_s;
    assign retire   = reset_n & retire_s;
    assign mem_req  = reset_n & mem_req_s;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; expected output words are hand-written per state.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, mem_req, retire, mem_timeout;
    logic [1:0] alusrca, alusrcb, resultsrc, aluop;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int errs   = 0;
    int checks = 0;

    // {pcwrite, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb, resultsrc, aluop, mem_req, retire}
    logic [14:0] outs;
    assign outs = {pcwrite, adrsrc, memwrite, irwrite, regwrite,
                   alusrca, alusrcb, resultsrc, aluop, mem_req, retire};

    localparam logic [14:0] O_RST  = 15'b0_0_0_0_0_00_10_10_00_0_0;
    localparam logic [14:0] O_FR   = 15'b1_0_0_1_0_00_10_10_00_1_0;
    localparam logic [14:0] O_FW   = 15'b0_0_0_0_0_00_10_10_00_1_0;
    localparam logic [14:0] O_DEC  = 15'b0_0_0_0_0_01_01_00_00_0_0;
    localparam logic [14:0] O_DNOP = 15'b0_0_0_0_0_01_01_00_00_0_1;
    localparam logic [14:0] O_MADR = 15'b0_0_0_0_0_10_01_00_00_0_0;
    localparam logic [14:0] O_MRD  = 15'b0_1_0_0_0_00_00_00_00_1_0;
    localparam logic [14:0] O_MWB  = 15'b0_0_0_0_1_00_00_01_00_0_1;
    localparam logic [14:0] O_MW1  = 15'b0_1_1_0_0_00_00_00_00_1_1;
    localparam logic [14:0] O_MW0  = 15'b0_1_0_0_0_00_00_00_00_1_0;
    localparam logic [14:0] O_EXR  = 15'b0_0_0_0_0_10_00_00_10_0_0;
    localparam logic [14:0] O_EXI  = 15'b0_0_0_0_0_10_01_00_10_0_0;
    localparam logic [14:0] O_AWB  = 15'b0_0_0_0_1_00_00_00_00_0_1;
    localparam logic [14:0] O_BEQ1 = 15'b1_0_0_0_0_10_00_00_01_0_1;
    localparam logic [14:0] O_BEQ0 = 15'b0_0_0_0_0_10_00_00_01_0_1;
    localparam logic [14:0] O_JAL  = 15'b1_0_0_0_0_01_10_00_00_0_0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam logic [14:0] O_TRAP = 15'b0;
`endif

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.WAIT_MAX(15)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .adrsrc      (adrsrc),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .resultsrc   (resultsrc),
        .aluop       (aluop),
        .mem_req     (mem_req),
        .retire      (retire),
        .mem_timeout (mem_timeout)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, let outputs settle, compare, then advance past the edge.
    task automatic cyc(input string tag, input logic rdy, input logic zr, input logic [14:0] exp);
        mem_ready = rdy;
        zero      = zr;
        #2;
        chk(tag, {1'b0, outs}, {1'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = LW;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tmo", {15'b0, mem_timeout}, 16'd0);
        cyc("rst_outs", 1'b1, 1'b0, O_RST);
        reset_n = 1'b1;

        // lw, no waits, then lw with one MEMREAD wait
        cyc("lw_fetch",  1, 0, O_FR);
        cyc("lw_dec",    1, 0, O_DEC);
        cyc("lw_madr",   1, 0, O_MADR);
        cyc("lw_mrd",    1, 0, O_MRD);
        cyc("lw_mwb",    1, 0, O_MWB);
        cyc("lw2_fetch", 1, 0, O_FR);
        cyc("lw2_dec",   1, 0, O_DEC);
        cyc("lw2_madr",  1, 0, O_MADR);
        cyc("lw2_mrdw",  0, 0, O_MRD);
        cyc("lw2_mrd",   1, 0, O_MRD);
        cyc("lw2_mwb",   1, 0, O_MWB);

        // sw with three MEMWRITE wait cycles
        op = SW;
        cyc("sw_fetch", 1, 0, O_FR);
        cyc("sw_dec",   1, 0, O_DEC);
        cyc("sw_madr",  1, 0, O_MADR);
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", 0, 0, O_MW0);
        cyc("sw_write", 1, 0, O_MW1);

        // beq taken, then not taken; zero is high in DECODE and must be ignored
        op = BEQ;
        cyc("beq1_fetch", 1, 0, O_FR);
        cyc("beq1_dec",   1, 1, O_DEC);
        cyc("beq1_beq",   1, 1, O_BEQ1);
        cyc("beq0_fetch", 1, 0, O_FR);
        cyc("beq0_dec",   1, 1, O_DEC);
        cyc("beq0_beq",   1, 0, O_BEQ0);

        op = RT;
        cyc("r_fetch", 1, 0, O_FR);
        cyc("r_dec",   1, 0, O_DEC);
        cyc("r_exec",  1, 0, O_EXR);
        cyc("r_wb",    1, 0, O_AWB);
        op = IT;
        cyc("i_fetch", 1, 0, O_FR);
        cyc("i_dec",   1, 0, O_DEC);
        cyc("i_exec",  1, 0, O_EXI);
        cyc("i_wb",    1, 0, O_AWB);
        op = JAL;
        cyc("jal_fetch", 1, 0, O_FR);
        cyc("jal_dec",   1, 0, O_DEC);
        cyc("jal_jal",   1, 0, O_JAL);
        cyc("jal_wb",    1, 0, O_AWB);

        // 20-cycle fetch stall: timeout appears after exactly 15 wait cycles and sticks
        op = IT;
        for (int i = 0; i < 20; i++) begin
            chk("tmo_wait", {15'b0, mem_timeout}, {15'b0, (i >= 15)});
            cyc("fetch_wait", 0, 0, O_FW);
        end
        cyc("tmo_fetch", 1, 0, O_FR);
        cyc("tmo_dec",   1, 0, O_DEC);
        cyc("tmo_exec",  1, 0, O_EXI);
        cyc("tmo_wb",    1, 0, O_AWB);
        chk("tmo_sticky", {15'b0, mem_timeout}, 16'd1);

        // reset asserted mid-wait with mem_ready high: no enable may rise
        op = SW;
        cyc("swr_fetch", 1, 0, O_FR);
        cyc("swr_dec",   1, 0, O_DEC);
        cyc("swr_madr",  1, 0, O_MADR);
        cyc("swr_wait",  0, 0, O_MW0);
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk("rstmid_outs", {1'b0, outs}, {1'b0, O_RST});
        chk("rstmid_tmo",  {15'b0, mem_timeout}, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc("swr2_fetch", 1, 0, O_FR);
        cyc("swr2_dec",   1, 0, O_DEC);
        cyc("swr2_madr",  1, 0, O_MADR);
        cyc("swr2_write", 1, 0, O_MW1);

        // unsupported opcode
        op = BAD;
        cyc("bad_fetch", 1, 0, O_FR);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        cyc("bad_dec", 1, 0, O_DEC);
        for (int i = 0; i < 3; i++) begin
            chk("trap_illegal", {15'b0, illegal}, 16'd1);
            cyc("trap_outs", 1, 0, O_TRAP);
        end
        reset_n = 1'b0;
        #2;
        chk("trap_rst_outs", {1'b0, outs}, {1'b0, O_RST});
        chk("trap_rst_ill",  {15'b0, illegal}, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        op = IT;
        cyc("trap_refetch", 1, 0, O_FR);
        cyc("trap_dec",     1, 0, O_DEC);
`else
        cyc("nop_dec",   1, 0, O_DNOP);
        op = IT;
        cyc("nop_fetch", 1, 0, O_FR);
        cyc("nop_next",  1, 0, O_DEC);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
